// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and default widths, common to PC, fetch and decode.
// Pure declarations: no logic, no latency, no flow control.
package instr_fetch_unit_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 24;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit signal bundle: PC side, instruction-memory req/ack side and decode side.
// master = fetch unit, slave = its environment (PC, memory, decode).
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] pc_addr;
    logic              fetch_en;
    logic              stall;
    logic              flush;
    logic              pc_inc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] ir_out;
    logic              ir_valid;
    logic              ir_ready;
    logic              fetch_err;
    logic              busy;

    modport master (
        input  pc_addr, fetch_en, stall, flush, mem_rdata, mem_ack, ir_ready,
        output pc_inc, mem_addr, mem_req, ir_out, ir_valid, fetch_err, busy
    );

    modport slave (
        output pc_addr, fetch_en, stall, flush, mem_rdata, mem_ack, ir_ready,
        input  pc_inc, mem_addr, mem_req, ir_out, ir_valid, fetch_err, busy
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_timer.sv
// Outstanding-request watchdog: counts enabled cycles from a clear, flags TIMEOUT-1.
// Expired is combinational from the count; the count holds once expired.
module fetch_timer
    import instr_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the word at the PC over req/ack into an instruction register; pulses pc_inc per fetch.
// Launch one cycle after IDLE qualifies; ir held until decode takes it (ir_ready & !stall) or flush.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              pc_inc_q, pc_inc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              fetch_err_q, fetch_err_d;

    logic tmr_active;
    logic tmr_expired;

    // The timer runs only while a request is outstanding and is zero on every launch.
    assign tmr_active = (state_q == WAIT) || (state_q == FLUSH);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!tmr_active),
        .en      (tmr_active),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        pc_inc_d    = 1'b0;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            IDLE: begin
                if (bus.fetch_en && !bus.stall && !bus.flush) begin
                    mem_addr_d = bus.pc_addr;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A response in the expiry cycle still counts as a completed fetch.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!bus.flush) begin
                        ir_d       = bus.mem_rdata;
                        ir_valid_d = 1'b1;
                        pc_inc_d   = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmr_expired) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (bus.flush) begin
                    state_d = FLUSH;
                end
            end
            HOLD: begin
                if (bus.flush || (bus.ir_ready && !bus.stall)) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            FLUSH: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (tmr_expired) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            pc_inc_q    <= 1'b0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            pc_inc_q    <= pc_inc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.pc_inc    = pc_inc_q;
    assign bus.ir_out    = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.fetch_err = fetch_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC model, latency-programmable memory responder,
// address and instruction scoreboards checked as launches and acceptances occur.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pc_addr;
    logic        fetch_en, stall, flush, ir_ready, mem_ack;
    logic [23:0] mem_rdata;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(24), .DATA_W(24)) fif ();

    assign fif.pc_addr   = pc_addr;
    assign fif.fetch_en  = fetch_en;
    assign fif.stall     = stall;
    assign fif.flush     = flush;
    assign fif.ir_ready  = ir_ready;
    assign fif.mem_ack   = mem_ack;
    assign fif.mem_rdata = mem_rdata;

    instr_fetch_unit #(
        .ADDR_W  (24),
        .DATA_W  (24),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif)
    );

    int n_cmp = 0;
    int n_err = 0;

    int  cyc, req_cnt, pcinc_cnt, launch_cnt, acc_cnt, ack_lat, wcnt;
    bit  auto_ack, req_prev, discard, pcinc_seen;
    logic [31:0] cur_addr;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];
    int          launch_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mem_word(input logic [23:0] a);
        return 24'hABCDEF + (a - 24'd100) * 24'h000111;
    endfunction

    // One clock: observe at the falling edge, then PC model and memory responder after the rise.
    task automatic tick();
        logic [31:0] exp_v;
        @(negedge clk);
        if (fif.mem_req && !req_prev) begin
            launch_cnt++;
            launch_cyc.push_back(cyc);
            exp_v = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
            cur_addr = exp_v;
            check("launch_addr", 32'(fif.mem_addr), exp_v);
        end
        if (fif.mem_req) req_cnt++;
        if (fif.pc_inc) begin
            pcinc_cnt++;
            pcinc_seen = 1'b1;
        end
        if (mem_ack && fif.mem_req && !flush && !discard)
            data_q.push_back(32'(mem_word(cur_addr[23:0])));
        if (fif.mem_req && flush) discard = 1'b1;
        else if (!fif.mem_req)    discard = 1'b0;
        if (fif.ir_valid && ir_ready && !stall && !flush) begin
            acc_cnt++;
            exp_v = (data_q.size() != 0) ? data_q.pop_front() : 32'hFFFF_FFFF;
            check("ir_accept", 32'(fif.ir_out), exp_v);
        end
        req_prev = fif.mem_req;

        @(posedge clk);
        #1;
        cyc++;
        if (pcinc_seen) begin
            pc_addr    = pc_addr + 24'd1;
            pcinc_seen = 1'b0;
        end
        if (auto_ack) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (fif.mem_req) begin
                if (wcnt == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(fif.mem_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    endtask

    task automatic wait_ir_valid(input int max_cyc);
        int k = 0;
        while (!fif.ir_valid && k < max_cyc) begin
            tick();
            k++;
        end
        check("ir_valid_wait", 32'(fif.ir_valid), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (fif.busy && k < max_cyc) begin
            tick();
            k++;
        end
        check("idle_wait", 32'(fif.busy), 32'd0);
    endtask

    task automatic launch_one(input logic [23:0] exp_addr);
        addr_q.push_back(32'(exp_addr));
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int g1, g2;
        reset = 1'b1; pc_addr = 24'd100; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
        ir_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        cyc = 0; req_cnt = 0; pcinc_cnt = 0; launch_cnt = 0; acc_cnt = 0; wcnt = 0;
        auto_ack = 1'b1; ack_lat = 2; req_prev = 1'b0; discard = 1'b0; pcinc_seen = 1'b0;
        cur_addr = '0;
        repeat (3) tick();

        check("rst_mem_req",   32'(fif.mem_req),   32'd0);
        check("rst_mem_addr",  32'(fif.mem_addr),  32'd0);
        check("rst_pc_inc",    32'(fif.pc_inc),    32'd0);
        check("rst_ir_out",    32'(fif.ir_out),    32'd0);
        check("rst_ir_valid",  32'(fif.ir_valid),  32'd0);
        check("rst_fetch_err", 32'(fif.fetch_err), 32'd0);
        check("rst_busy",      32'(fif.busy),      32'd0);
        reset = 1'b0;
        tick();

        // Basic fetch, ack two cycles after the request
        req_cnt = 0; pcinc_cnt = 0;
        launch_one(24'd100);
        wait_ir_valid(20);
        check("basic_req_cycles", 32'(req_cnt),      32'd3);
        check("basic_ir_out",     32'(fif.ir_out),   32'hABCDEF);
        check("basic_pc_inc",     32'(fif.pc_inc),   32'd1);
        check("basic_mem_req",    32'(fif.mem_req),  32'd0);
        check("basic_mem_addr",   32'(fif.mem_addr), 32'd100);
        tick();
        check("basic_pc_inc_clr", 32'(fif.pc_inc),   32'd0);
        check("basic_pcinc_cnt",  32'(pcinc_cnt),    32'd1);
        check("basic_pc_model",   32'(pc_addr),      32'd101);
        ir_ready = 1'b1;
        tick();
        check("basic_ir_consumed", 32'(fif.ir_valid), 32'd0);

        // Back-to-back fetches with ack latency 1 and decode always ready
        pc_addr = 24'd100; ack_lat = 1;
        addr_q.push_back(32'd100); addr_q.push_back(32'd101); addr_q.push_back(32'd102);
        launch_cnt = 0; acc_cnt = 0; pcinc_cnt = 0; launch_cyc.delete();
        fetch_en = 1'b1;
        k = 0;
        while (launch_cnt < 3 && k < 60) begin tick(); k++; end
        fetch_en = 1'b0;
        k = 0;
        while ((acc_cnt < 3 || fif.busy) && k < 60) begin tick(); k++; end
        check("b2b_launches",  32'(launch_cnt), 32'd3);
        check("b2b_accepted",  32'(acc_cnt),    32'd3);
        check("b2b_pcinc_cnt", 32'(pcinc_cnt),  32'd3);
        check("b2b_pc_final",  32'(pc_addr),    32'd103);
        g1 = (launch_cyc.size() >= 3) ? launch_cyc[1] - launch_cyc[0] : -1;
        g2 = (launch_cyc.size() >= 3) ? launch_cyc[2] - launch_cyc[1] : -1;
        check("b2b_gap1", 32'(g1), 32'd4);
        check("b2b_gap2", 32'(g2), 32'd4);

        // Decode back-pressure holds the instruction register
        ir_ready = 1'b0;
        launch_one(24'd103);
        wait_ir_valid(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ir_valid", 32'(fif.ir_valid), 32'd1);
            check("hold_ir_out",   32'(fif.ir_out),   32'(mem_word(24'd103)));
            check("hold_no_req",   32'(fif.mem_req),  32'd0);
        end
        ir_ready = 1'b1; stall = 1'b1;
        repeat (2) tick();
        check("stall_blocks_accept", 32'(fif.ir_valid), 32'd1);
        addr_q.push_back(32'd104);
        stall = 1'b0; fetch_en = 1'b1;
        tick();
        check("accept_ir_valid",   32'(fif.ir_valid), 32'd0);
        check("accept_no_req_yet", 32'(fif.mem_req),  32'd0);
        tick();
        check("relaunch_req", 32'(fif.mem_req), 32'd1);
        fetch_en = 1'b0;
        wait_idle(20);

        stall = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_idle_req", 32'(fif.mem_req), 32'd0);
        end
        check("stall_idle_busy", 32'(fif.busy), 32'd0);
        stall = 1'b0; fetch_en = 1'b0;

        // Flush during WAIT, memory acks in the fourth request cycle
        ack_lat = 3; pcinc_cnt = 0;
        launch_one(24'd105);
        tick();
        flush = 1'b1; pc_addr = 24'd200;
        tick();
        flush = 1'b0;
        check("flush_req_held_a", 32'(fif.mem_req), 32'd1);
        check("flush_busy",       32'(fif.busy),    32'd1);
        tick();
        check("flush_req_held_b", 32'(fif.mem_req), 32'd1);
        tick();
        check("flush_req_drop",  32'(fif.mem_req),  32'd0);
        check("flush_ir_valid",  32'(fif.ir_valid), 32'd0);
        check("flush_idle",      32'(fif.busy),     32'd0);
        check("flush_no_pc_inc", 32'(pcinc_cnt),    32'd0);
        launch_one(24'd200);
        wait_idle(20);
        check("redirect_pc", 32'(pc_addr), 32'd201);

        // Flush coincident with the ack
        ack_lat = 1; pcinc_cnt = 0;
        launch_one(24'd201);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ack_req",      32'(fif.mem_req),  32'd0);
        check("flush_ack_ir_valid", 32'(fif.ir_valid), 32'd0);
        check("flush_ack_idle",     32'(fif.busy),     32'd0);
        tick();
        check("flush_ack_no_pc_inc", 32'(pcinc_cnt), 32'd0);

        // Timeout: memory never answers
        auto_ack = 1'b0; mem_ack = 1'b0; req_cnt = 0;
        launch_one(24'd201);
        k = 0;
        while (fif.mem_req && k < 40) begin tick(); k++; end
        check("timeout_req_cycles", 32'(req_cnt),       32'd16);
        check("timeout_err",        32'(fif.fetch_err), 32'd1);
        check("timeout_idle",       32'(fif.busy),      32'd0);
        mem_ack = 1'b1; mem_rdata = 24'h123456;
        tick();
        mem_ack = 1'b0;
        tick();
        check("late_ack_ir_valid", 32'(fif.ir_valid),  32'd0);
        check("late_ack_err",      32'(fif.fetch_err), 32'd1);
        check("late_ack_no_inc",   32'(pcinc_cnt),     32'd0);
        check("late_ack_idle",     32'(fif.busy),      32'd0);

        // Asynchronous reset in the middle of WAIT
        launch_one(24'd201);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_mem_req",   32'(fif.mem_req),   32'd0);
        check("arst_mem_addr",  32'(fif.mem_addr),  32'd0);
        check("arst_ir_out",    32'(fif.ir_out),    32'd0);
        check("arst_ir_valid",  32'(fif.ir_valid),  32'd0);
        check("arst_fetch_err", 32'(fif.fetch_err), 32'd0);
        check("arst_busy",      32'(fif.busy),      32'd0);
        check("arst_pc_inc",    32'(fif.pc_inc),    32'd0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 24'h777777;
        tick();
        mem_ack = 1'b0;
        check("post_rst_ack_busy",  32'(fif.busy),     32'd0);
        check("post_rst_ack_valid", 32'(fif.ir_valid), 32'd0);
        check("post_rst_ack_ir",    32'(fif.ir_out),   32'd0);
        tick();
        check("post_rst_no_pc_inc", 32'(pcinc_cnt), 32'd0);

        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
